// File: rtl/frame_pkg.sv
// Shared state encoding and sizing constants for the frame sequencing controller.
package frame_pkg;

    localparam int unsigned PIXEL_NUM_DEF = 16384;
    localparam int unsigned PIXEL_W       = 24;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LD_WAIT = 3'd1,
        ST_LOAD    = 3'd2,
        ST_DR_WAIT = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/frame_seq_ctrl_if.sv
// Source, frame-buffer and downstream handshake bundle seen by frame_seq_ctrl.
interface frame_seq_ctrl_if;

    logic src_ready;
    logic src_en;
    logic fb_rcv_req;
    logic fb_rcv_ack;
    logic fb_snd_req;
    logic fb_snd_ack;
    logic dst_ready;
    logic dst_valid;
    logic dst_last;

    modport master (
        input  src_ready, fb_rcv_req, fb_snd_ack, dst_ready,
        output src_en, fb_rcv_ack, fb_snd_req, dst_valid, dst_last
    );

    modport slave (
        output src_ready, fb_rcv_req, fb_snd_ack, dst_ready,
        input  src_en, fb_rcv_ack, fb_snd_req, dst_valid, dst_last
    );

endinterface

// File: rtl/beat_counter.sv
// Clear/load/enable up-counter with a terminal-count flag at TERM.
module beat_counter #(
    parameter int unsigned W    = 4,
    parameter int unsigned TERM = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_tc_c
);

    logic [W-1:0] r_cnt;

    // Clear wins over load, load wins over count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_tc_c = (r_cnt == W'(TERM));

endmodule

// File: rtl/frame_seq_ctrl.sv
// Load/drain sequencer for one frame buffer; FRAME_SEQ_CTRL_TIMEOUT_EN adds a
// wait-state watchdog driving the sticky err flag.
module frame_seq_ctrl
    import frame_pkg::*;
#(
    parameter int unsigned PIXEL_NUM   = PIXEL_NUM_DEF,
    parameter int unsigned CNT_W       = $clog2(PIXEL_NUM),
    parameter int unsigned FCNT_W      = 16
`ifdef FRAME_SEQ_CTRL_TIMEOUT_EN
   ,parameter int unsigned TIMEOUT_CYC = 65535
`endif
) (
    input  logic                clk,
    input  logic                xrst,
    input  logic                start,
    input  logic                cont,
    frame_seq_ctrl_if.master    bus,
    output logic                busy,
    output logic                frame_done,
    output logic [FCNT_W-1:0]   frame_cnt,
    output logic                err
);

    state_t            r_state, w_state_nx;
    logic              r_rcv_ack, r_src_en, r_snd_req, r_valid, r_last, r_done;
    logic [FCNT_W-1:0] r_fcnt;
    logic              w_rcv_ack_nx, w_src_en_nx, w_snd_req_nx, w_valid_nx, w_last_nx;
    logic              w_ld_en, w_ld_clr, w_ld_tc;
    logic              w_dr_en, w_dr_clr, w_dr_tc;
    logic              w_beat;

`ifdef FRAME_SEQ_CTRL_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC);
    logic r_err, w_err_nx, w_wd_tc, w_in_wait;
`endif

    // A drain beat is any fb_snd_ack cycle once the send request has been seen.
    assign w_beat = bus.fb_snd_ack &&
                    ((r_state == ST_DRAIN) || ((r_state == ST_DR_WAIT) && r_snd_req));

    always_comb begin
        w_state_nx   = r_state;
        w_rcv_ack_nx = 1'b0;
        w_src_en_nx  = 1'b0;
        w_snd_req_nx = 1'b0;
        w_valid_nx   = 1'b0;
        w_last_nx    = 1'b0;
        w_ld_en      = 1'b0;
        w_ld_clr     = 1'b1;
        w_dr_en      = 1'b0;
        w_dr_clr     = 1'b1;
`ifdef FRAME_SEQ_CTRL_TIMEOUT_EN
        w_err_nx     = r_err;
`endif
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nx = ST_LD_WAIT;
`ifdef FRAME_SEQ_CTRL_TIMEOUT_EN
                    w_err_nx   = 1'b0;
`endif
                end
            end
            ST_LD_WAIT: begin
                // Ack is visible for one cycle; the source is enabled the cycle after.
                if (r_rcv_ack) begin
                    w_state_nx  = ST_LOAD;
                    w_src_en_nx = 1'b1;
                end else if (bus.fb_rcv_req && bus.src_ready) begin
                    w_rcv_ack_nx = 1'b1;
                end
`ifdef FRAME_SEQ_CTRL_TIMEOUT_EN
                else if (w_wd_tc) begin
                    w_state_nx = ST_IDLE;
                    w_err_nx   = 1'b1;
                end
`endif
            end
            ST_LOAD: begin
                w_ld_en  = 1'b1;
                w_ld_clr = w_ld_tc;
                if (w_ld_tc) begin
                    w_state_nx = ST_DR_WAIT;
                end else begin
                    w_src_en_nx = 1'b1;
                end
            end
            ST_DR_WAIT, ST_DRAIN: begin
                w_dr_clr = 1'b0;
                if ((r_state == ST_DR_WAIT) && !w_beat) begin
                    w_snd_req_nx = r_snd_req || bus.dst_ready;
                end
                if (w_beat) begin
                    w_valid_nx = 1'b1;
                    if (w_dr_tc) begin
                        w_last_nx  = 1'b1;
                        w_dr_clr   = 1'b1;
                        w_state_nx = ST_DONE;
                    end else begin
                        w_dr_en    = 1'b1;
                        w_state_nx = ST_DRAIN;
                    end
                end
`ifdef FRAME_SEQ_CTRL_TIMEOUT_EN
                // The buffer holds a frame here, so a timeout only flags.
                if ((r_state == ST_DR_WAIT) && w_wd_tc) begin
                    w_err_nx = 1'b1;
                end
`endif
            end
            ST_DONE: begin
                w_state_nx = cont ? ST_LD_WAIT : ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_state   <= ST_IDLE;
            r_rcv_ack <= 1'b0;
            r_src_en  <= 1'b0;
            r_snd_req <= 1'b0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_done    <= 1'b0;
            r_fcnt    <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_rcv_ack <= w_rcv_ack_nx;
            r_src_en  <= w_src_en_nx;
            r_snd_req <= w_snd_req_nx;
            r_valid   <= w_valid_nx;
            r_last    <= w_last_nx;
            r_done    <= (w_state_nx == ST_DONE);
            if (w_state_nx == ST_DONE) begin
                r_fcnt <= r_fcnt + FCNT_W'(1);
            end
        end
    end

    beat_counter #(.W(CNT_W), .TERM(PIXEL_NUM - 1)) u_ld_cnt (
        .clk        (clk),
        .rst_n      (xrst),
        .i_clr      (w_ld_clr),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (w_ld_en),
        .o_tc_c     (w_ld_tc)
    );

    beat_counter #(.W(CNT_W), .TERM(PIXEL_NUM - 1)) u_dr_cnt (
        .clk        (clk),
        .rst_n      (xrst),
        .i_clr      (w_dr_clr),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (w_dr_en),
        .o_tc_c     (w_dr_tc)
    );

`ifdef FRAME_SEQ_CTRL_TIMEOUT_EN
    assign w_in_wait = (r_state == ST_LD_WAIT) || (r_state == ST_DR_WAIT);

    // Restarts on every state change and saturates at the limit.
    beat_counter #(.W(WD_W), .TERM(TIMEOUT_CYC - 1)) u_wd_cnt (
        .clk        (clk),
        .rst_n      (xrst),
        .i_clr      (!w_in_wait || (w_state_nx != r_state)),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (!w_wd_tc),
        .o_tc_c     (w_wd_tc)
    );

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_nx;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign busy           = (r_state != ST_IDLE);
    assign frame_done     = r_done;
    assign frame_cnt      = r_fcnt;
    assign bus.fb_rcv_ack = r_rcv_ack;
    assign bus.src_en     = r_src_en;
    assign bus.fb_snd_req = r_snd_req;
    assign bus.dst_valid  = r_valid;
    assign bus.dst_last   = r_last;

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Directed bench for frame_seq_ctrl with a small behavioural frame buffer and pixel source.
module tb_frame_seq_ctrl;
    import frame_pkg::*;

    localparam int unsigned N      = 16;
    localparam int unsigned FCNT_W = 16;

    logic              clk = 1'b0;
    logic              xrst, start, cont;
    logic              busy, frame_done, err;
    logic [FCNT_W-1:0] frame_cnt;

    frame_seq_ctrl_if bus ();

    frame_seq_ctrl #(
        .PIXEL_NUM   (N),
        .FCNT_W      (FCNT_W)
`ifdef FRAME_SEQ_CTRL_TIMEOUT_EN
       ,.TIMEOUT_CYC (20)
`endif
    ) dut (
        .clk        (clk),
        .xrst       (xrst),
        .start      (start),
        .cont       (cont),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Frame buffer model: one-cycle registered read while fb_snd_ack is high.
    typedef enum logic [1:0] {FB_EMPTY, FB_FILL, FB_FULL, FB_READ} fb_st_t;
    fb_st_t             fb_st;
    int                 wr_ptr, rd_ptr, gap_left;
    int                 gap_at   = -1;
    int                 src_base = 0;
    logic [PIXEL_W-1:0] mem [N];
    logic [PIXEL_W-1:0] pix_in, pix_out;

    assign pix_in = PIXEL_W'(src_base + wr_ptr);

    always @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            fb_st          <= FB_EMPTY;
            wr_ptr         <= 0;
            rd_ptr         <= 0;
            gap_left       <= 0;
            pix_out        <= '0;
            bus.fb_rcv_req <= 1'b0;
            bus.fb_snd_ack <= 1'b0;
        end else begin
            case (fb_st)
                FB_EMPTY: begin
                    bus.fb_rcv_req <= 1'b1;
                    if (bus.fb_rcv_req && bus.fb_rcv_ack) begin
                        bus.fb_rcv_req <= 1'b0;
                        wr_ptr         <= 0;
                        fb_st          <= FB_FILL;
                    end
                end
                FB_FILL: begin
                    if (bus.src_en) begin
                        mem[wr_ptr] <= pix_in;
                        wr_ptr      <= wr_ptr + 1;
                        if (wr_ptr == N - 1) fb_st <= FB_FULL;
                    end
                end
                FB_FULL: begin
                    if (bus.fb_snd_req) begin
                        bus.fb_snd_ack <= 1'b1;
                        rd_ptr         <= 0;
                        fb_st          <= FB_READ;
                    end
                end
                default: begin
                    if (bus.fb_snd_ack) begin
                        pix_out <= mem[rd_ptr];
                        rd_ptr  <= rd_ptr + 1;
                        if (rd_ptr == N - 1) begin
                            bus.fb_snd_ack <= 1'b0;
                            fb_st          <= FB_EMPTY;
                        end else if (rd_ptr == gap_at) begin
                            bus.fb_snd_ack <= 1'b0;
                            gap_left       <= 2;
                        end
                    end else begin
                        if (gap_left == 1) bus.fb_snd_ack <= 1'b1;
                        gap_left <= gap_left - 1;
                    end
                end
            endcase
        end
    end

    // Monitor: event counters plus per-beat pixel/last checks.
    int   n_ack = 0, n_src = 0, n_valid = 0, n_last = 0, n_done = 0, n_idle = 0, n_seq_err = 0;
    int   beat = 0;
    logic prev_ack = 1'b0, prev_en = 1'b0;

    always @(negedge clk) begin
        if (!xrst) begin
            beat     = 0;
            prev_ack = 1'b0;
            prev_en  = 1'b0;
        end else begin
            if (bus.fb_rcv_ack) n_ack++;
            if (bus.src_en)     n_src++;
            if (!busy)          n_idle++;
            if (frame_done)     n_done++;
            if ((prev_ack && !bus.src_en) || (bus.src_en && !prev_en && !prev_ack) ||
                (bus.dst_last && !bus.dst_valid))
                n_seq_err++;
            if (bus.dst_valid) begin
                n_valid++;
                check("pixel", 32'(pix_out), 32'(src_base + beat));
                if (bus.dst_last) begin
                    n_last++;
                    check("last_beat_idx", 32'(beat), 32'(N - 1));
                    beat = 0;
                end else begin
                    beat++;
                end
            end
            prev_ack = bus.fb_rcv_ack;
            prev_en  = bus.src_en;
        end
    end

    int s_ack, s_src, s_valid, s_last, s_done, s_idle, s_seq;

    task automatic snap();
        s_ack = n_ack; s_src = n_src; s_valid = n_valid; s_last = n_last;
        s_done = n_done; s_idle = n_idle; s_seq = n_seq_err;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget);
        int k = 0;
        int c = 0;
        while (k < n && c < budget) begin
            @(negedge clk);
            c++;
            if (frame_done) begin
                k++;
                if (k == n) cont = 1'b0;
            end
        end
        check("done_pulses", 32'(k), 32'(n));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},   32'(busy),           32'd0);
        check({tag, "_src_en"}, 32'(bus.src_en),     32'd0);
        check({tag, "_rcvack"}, 32'(bus.fb_rcv_ack), 32'd0);
        check({tag, "_sndreq"}, 32'(bus.fb_snd_req), 32'd0);
        check({tag, "_valid"},  32'(bus.dst_valid),  32'd0);
        check({tag, "_last"},   32'(bus.dst_last),   32'd0);
        check({tag, "_done"},   32'(frame_done),     32'd0);
        check({tag, "_fcnt"},   32'(frame_cnt),      32'd0);
        check({tag, "_err"},    32'(err),            32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int c;
        int bad;
        xrst = 1'b0; start = 1'b0; cont = 1'b0;
        bus.src_ready = 1'b1; bus.dst_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk) xrst = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame, pixels 0x000000..0x00000F; a stray start during LOAD is ignored.
        src_base = 0;
        snap();
        pulse_start();
        c = 0;
        while (!bus.src_en && c < 50) begin @(negedge clk); c++; end
        pulse_start();
        wait_done(1, 300);
        repeat (6) @(negedge clk);
        check("f1_rcv_ack",  32'(n_ack - s_ack),     32'd1);
        check("f1_src_en",   32'(n_src - s_src),     32'(N));
        check("f1_valid",    32'(n_valid - s_valid), 32'(N));
        check("f1_last",     32'(n_last - s_last),   32'd1);
        check("f1_seq",      32'(n_seq_err - s_seq), 32'd0);
        check("f1_fcnt",     32'(frame_cnt),         32'd1);
        check("f1_idle",     32'(busy),              32'd0);

        // Continuous mode: three back-to-back frames without returning to IDLE.
        src_base = 'h100;
        cont = 1'b1;
        snap();
        pulse_start();
        s_idle = n_idle;
        wait_done(3, 1000);
        check("cont_idle_cycles", 32'(n_idle - s_idle), 32'd0);
        repeat (6) @(negedge clk);
        check("cont_done",   32'(n_done - s_done),   32'd3);
        check("cont_valid",  32'(n_valid - s_valid), 32'(3 * N));
        check("cont_fcnt",   32'(frame_cnt),         32'd4);
        check("cont_idle",   32'(busy),              32'd0);

        // dst_ready low after LOAD holds DR_WAIT; a mid-drain drop is ignored.
        src_base = 'h200;
        bus.dst_ready = 1'b0;
        snap();
        pulse_start();
        c = 0;
        while (!bus.src_en && c < 50)  begin @(negedge clk); c++; end
        while (bus.src_en && c < 100)  begin @(negedge clk); c++; end
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.fb_snd_req || !busy || bus.dst_valid) bad++;
        end
        check("drwait_hold", 32'(bad), 32'd0);
        bus.dst_ready = 1'b1;
        c = 0;
        while (!bus.dst_valid && c < 50) begin @(negedge clk); c++; end
        bus.dst_ready = 1'b0;
        wait_done(1, 200);
        bus.dst_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("dr_valid",    32'(n_valid - s_valid), 32'(N));
        check("dr_fcnt",     32'(frame_cnt),         32'd5);
`ifdef FRAME_SEQ_CTRL_TIMEOUT_EN
        check("dr_err",      32'(err),               32'd1);
`else
        check("dr_err",      32'(err),               32'd0);
`endif

        // fb_snd_ack gap mid-drain: still exactly N valid beats.
        src_base = 'h300;
        gap_at = 5;
        snap();
        pulse_start();
        wait_done(1, 300);
        repeat (6) @(negedge clk);
        gap_at = -1;
        check("gap_valid",   32'(n_valid - s_valid), 32'(N));
        check("gap_last",    32'(n_last - s_last),   32'd1);
        check("gap_fcnt",    32'(frame_cnt),         32'd6);

        // Asynchronous reset on drain beat 7, then a clean frame.
        src_base = 'h400;
        pulse_start();
        c = 0;
        bad = 0;
        while (bad < 8 && c < 300) begin
            @(negedge clk);
            c++;
            if (bus.dst_valid) bad++;
        end
        check("rst_reached_beat7", 32'(bad), 32'd8);
        #2 xrst = 1'b0;
        #1;
        check_outputs_zero("midrst");
        repeat (2) @(negedge clk);
        xrst = 1'b1;
        src_base = 'h500;
        repeat (2) @(negedge clk);
        snap();
        pulse_start();
        wait_done(1, 300);
        repeat (6) @(negedge clk);
        check("post_rst_valid", 32'(n_valid - s_valid), 32'(N));
        check("post_rst_last",  32'(n_last - s_last),   32'd1);
        check("post_rst_fcnt",  32'(frame_cnt),         32'd1);

`ifdef FRAME_SEQ_CTRL_TIMEOUT_EN
        // Watchdog in LD_WAIT: err after 20 wait cycles, back to IDLE, cleared by next start.
        bus.src_ready = 1'b0;
        pulse_start();
        c = 1;
        while (!err && c < 100) begin @(negedge clk); c++; end
        check("wd_cycle",    32'(c),    32'd21);
        check("wd_err",      32'(err),  32'd1);
        check("wd_idle",     32'(busy), 32'd0);
        bus.src_ready = 1'b1;
        pulse_start();
        check("wd_err_clr",  32'(err),  32'd0);
        wait_done(1, 300);
        repeat (4) @(negedge clk);
        check("wd_fcnt",     32'(frame_cnt), 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
